// File: rtl/clk_div_prog_pkg.sv
// Shared constants and divisor helpers for the programmable clock divider.
// Helpers work on 32-bit values so callers of any WIDTH up to 31 cannot overflow.
package clk_div_prog_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_RESET_DIV = 5;

    // High-phase length: ceil(d/2).
    function automatic logic [31:0] ceil_half(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

    // A divisor of 0 is meaningless; treat it as divide-by-1.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clk_div_mod_cnt.sv
// Modulo-N phase counter with enable and synchronous reset.
// wrap is high during the enabled cycle whose rising edge returns cnt to 0.
module clk_div_mod_cnt
    import clk_div_prog_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign wrap = en && (cnt == (modulus - ONE));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: registered clk_out (duty ceil(N/2)/N),
// a one-cycle tick per period, and a divisor slot applied only at a period boundary.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RESET_DIV = DEF_RESET_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             tick,
    output logic             clk_out,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] div_cur
);

    logic [WIDTH-1:0] pend_div;
    logic             pend_valid;
    logic             wrap;
    logic             accept;
    logic             apply;
    logic [WIDTH-1:0] half;

    clk_div_mod_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk_in  (clk_in),
        .reset   (reset),
        .en      (en),
        .modulus (div_cur),
        .cnt     (cnt),
        .wrap    (wrap)
    );

    // Handshake: a divisor transfers on any edge where div_valid && div_ready.
    // div_ready is low exactly while the slot holds an unapplied divisor; valid
    // during that time is ignored. The slot drains only on a wrap edge, so a value
    // captured on a wrap edge waits for the next wrap.
    assign div_ready = !pend_valid;
    assign accept    = div_valid && !pend_valid;
    assign apply     = wrap && pend_valid;
    assign half      = WIDTH'(ceil_half(32'(div_cur)));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            div_cur    <= WIDTH'(RESET_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
        end else begin
            if (apply) begin
                div_cur    <= pend_div;
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_div   <= WIDTH'(clamp_div(32'(div_in)));
                pend_valid <= 1'b1;
            end
            // Outputs on the apply edge still reflect the outgoing divisor.
            tick <= wrap;
            if (en) begin
                clk_out <= (cnt < half);
            end
        end
    end

endmodule
